// File: rtl/dc_trigger.sv
// rtl/dc_trigger.sv - level/edge sample trigger with holdoff, decimated capture and bus registers
// Optional capture timestamp register: define DC_TRIGGER_TSTAMP_EN.
module dc_trigger #(
    parameter int BUS_ADDR_WIDTH = -1,
    parameter int BASE_ADDR      = 0,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                                                   clk,
    input  logic                                                   resetn,
    input  logic signed [DATA_WIDTH-1:0]                           din,
    input  logic                                                   din_valid,
    output logic signed [DATA_WIDTH-1:0]                           dout,
    output logic                                                   we,
    input  logic [((BUS_ADDR_WIDTH > 0) ? BUS_ADDR_WIDTH : 1)-1:0] bus_addr,
    input  logic [31:0]                                            bus_wdata,
    output logic [31:0]                                            bus_rdata,
    output logic                                                   bus_rvalid,
    input  logic                                                   bus_wr,
    input  logic                                                   bus_rd
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    state_t                        state;
    logic                          done;
    logic                          ctrl_arm, ctrl_edge, ctrl_pol;
    logic signed [DATA_WIDTH-1:0]  thresh;
    logic [15:0]                   decim, length, holdoff;
    logic [15:0]                   hcnt, dcnt, ecnt;
    logic                          prev_valid, prev_meet, force_pend;
    logic [31:0]                   rd_val;
`ifdef DC_TRIGGER_TSTAMP_EN
    logic [31:0]                   tcnt, tstamp;
`endif

    logic [31:0] addr_word, off_full;
    logic [2:0]  off;
    logic        mapped, wr_hit, ctrl_wr, force_wr, meet, cond_trig, fire, last;
    logic [15:0] ecnt_inc;
    logic        unused;

    assign addr_word = 32'(bus_addr);
    assign off_full  = addr_word - BASE;
    assign mapped    = (addr_word >= BASE) && (off_full < 32'd8);
    assign off       = off_full[2:0];
    assign wr_hit    = bus_wr && mapped;
    assign ctrl_wr   = wr_hit && (off == 3'd1);
    // An arm+force write while waiting is a force, not a re-arm.
    assign force_wr  = ctrl_wr && bus_wdata[0] && bus_wdata[3] && (state == S_WAIT);
    assign meet      = ctrl_pol ? (din <= thresh) : (din >= thresh);
    assign cond_trig = ctrl_edge ? (prev_valid && !prev_meet && meet) : meet;
    assign fire      = din_valid && (cond_trig || force_pend || force_wr);
    assign ecnt_inc  = ecnt + 16'd1;
    assign last      = (length != 16'd0) && (ecnt_inc == length);
    assign unused    = ^bus_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_arm  <= 1'b0;
            ctrl_edge <= 1'b0;
            ctrl_pol  <= 1'b0;
            thresh    <= '0;
            decim     <= '0;
            length    <= '0;
            holdoff   <= '0;
        end else if (wr_hit) begin
            case (off)
                3'd1: begin
                    ctrl_arm  <= bus_wdata[0];
                    ctrl_edge <= bus_wdata[1];
                    ctrl_pol  <= bus_wdata[2];
                end
                3'd2:    thresh  <= DATA_WIDTH'(bus_wdata);
                3'd3:    decim   <= bus_wdata[15:0];
                3'd4:    length  <= bus_wdata[15:0];
                3'd6:    holdoff <= bus_wdata[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            hcnt       <= '0;
            dcnt       <= '0;
            ecnt       <= '0;
            prev_valid <= 1'b0;
            prev_meet  <= 1'b0;
            force_pend <= 1'b0;
            dout       <= '0;
            we         <= 1'b0;
`ifdef DC_TRIGGER_TSTAMP_EN
            tstamp     <= '0;
`endif
        end else begin
            we <= 1'b0;
            if (ctrl_wr && !force_wr) begin
                force_pend <= 1'b0;
                done       <= 1'b0;
                ecnt       <= '0;
                if (bus_wdata[0]) begin
                    state <= S_HOLDOFF;
                    hcnt  <= holdoff;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_HOLDOFF: begin
                        if (hcnt <= 16'd1) begin
                            state      <= S_WAIT;
                            prev_valid <= 1'b0;
                        end else begin
                            hcnt <= hcnt - 16'd1;
                        end
                    end
                    S_WAIT: begin
                        if (fire) begin
                            state      <= last ? S_DONE : S_CAPT;
                            done       <= last;
                            force_pend <= 1'b0;
                            dout       <= din;
                            we         <= 1'b1;
                            ecnt       <= ecnt_inc;
                            dcnt       <= (decim == 16'd0) ? 16'd0 : 16'd1;
`ifdef DC_TRIGGER_TSTAMP_EN
                            tstamp     <= tcnt;
`endif
                        end else begin
                            if (force_wr) force_pend <= 1'b1;
                            if (din_valid) begin
                                prev_valid <= 1'b1;
                                prev_meet  <= meet;
                            end
                        end
                    end
                    S_CAPT: begin
                        if (din_valid) begin
                            dcnt <= (dcnt >= decim) ? 16'd0 : dcnt + 16'd1;
                            if (dcnt == 16'd0) begin
                                dout <= din;
                                we   <= 1'b1;
                                ecnt <= ecnt_inc;
                                if (last) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DC_TRIGGER_TSTAMP_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tcnt <= '0;
        else         tcnt <= tcnt + 32'd1;
    end
`endif

    always_comb begin
        rd_val = 32'd0;
        case (off)
            3'd0: rd_val = 32'h0000_7C16;
            3'd1: rd_val = {29'd0, ctrl_pol, ctrl_edge, ctrl_arm};
            3'd2: rd_val = 32'(thresh);
            3'd3: rd_val = {16'd0, decim};
            3'd4: rd_val = {16'd0, length};
            3'd5: rd_val = {28'd0, done, state};
            3'd6: rd_val = {16'd0, holdoff};
`ifdef DC_TRIGGER_TSTAMP_EN
            3'd7: rd_val = tstamp;
`endif
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            bus_rvalid <= bus_rd && mapped;
            bus_rdata  <= (bus_rd && mapped) ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_dc_trigger.sv
// tb/tb_dc_trigger.sv - randomized and directed self-checking bench for dc_trigger
module tb_dc_trigger;

    localparam int AW   = 8;
    localparam int BASE = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic signed [15:0] din;
    logic               din_valid;
    logic signed [15:0] dout;
    logic               we;
    logic [AW-1:0]      bus_addr;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;
    logic               bus_rvalid;
    logic               bus_wr;
    logic               bus_rd;

    dc_trigger #(.BUS_ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DATA_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .dout(dout), .we(we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_wr(bus_wr), .bus_rd(bus_rd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: states 0 idle, 1 holdoff, 2 wait, 3 capture, 4 done
    int          m_state, m_hold, m_k, m_emit;
    bit          m_pv, m_pm, m_fp, m_done;
    bit          r_arm, r_edge, r_pol;
    int          r_thr, r_dec, r_len, r_hold;
    bit [31:0]   m_tcnt, m_ts;
    bit          e_we, e_rv;
    int          e_dout;
    bit [31:0]   e_rd;

    int          got[$];
    bit [31:0]   last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_k = 0; m_emit = 0;
        m_pv = 0; m_pm = 0; m_fp = 0; m_done = 0;
        r_arm = 0; r_edge = 0; r_pol = 0;
        r_thr = 0; r_dec = 0; r_len = 0; r_hold = 0;
        m_tcnt = 0; m_ts = 0; e_we = 0; e_dout = 0; e_rv = 0; e_rd = 0;
    endtask

    task automatic emit_sample(input int sd);
        if (m_k % (r_dec + 1) == 0) begin
            e_we = 1; e_dout = sd; m_emit++;
            if (r_len != 0 && m_emit == r_len) begin
                m_state = 4; m_done = 1;
            end
        end
        m_k++;
    endtask

    task automatic model_step();
        int off, sd;
        bit mapped, ctrl, frc, meet, trig;
        mapped = (bus_addr >= BASE) && (bus_addr < BASE + 8);
        off    = int'(bus_addr) - BASE;
        sd     = din;
        e_rv   = bus_rd && mapped;
        e_rd   = 0;
        if (e_rv) begin
            case (off)
                0: e_rd = 32'h7C16;
                1: e_rd = {29'd0, r_pol, r_edge, r_arm};
                2: e_rd = 32'(r_thr);
                3: e_rd = 32'(r_dec);
                4: e_rd = 32'(r_len);
                5: e_rd = 32'(m_state) | (m_done ? 32'h8 : 32'h0);
                6: e_rd = 32'(r_hold);
`ifdef DC_TRIGGER_TSTAMP_EN
                7: e_rd = m_ts;
`endif
                default: e_rd = 0;
            endcase
        end
        e_we = 0;
        ctrl = bus_wr && mapped && off == 1;
        frc  = ctrl && bus_wdata[0] && bus_wdata[3] && m_state == 2;
        meet = r_pol ? (sd <= r_thr) : (sd >= r_thr);
        if (ctrl && !frc) begin
            m_fp = 0; m_done = 0; m_emit = 0;
            if (bus_wdata[0]) begin
                m_state = 1;
                m_hold  = (r_hold == 0) ? 1 : r_hold;
            end else begin
                m_state = 0;
            end
        end else begin
            case (m_state)
                1: begin
                    m_hold--;
                    if (m_hold == 0) begin m_state = 2; m_pv = 0; end
                end
                2: begin
                    trig = din_valid && (m_fp || frc || (r_edge ? (m_pv && !m_pm && meet) : meet));
                    if (trig) begin
                        m_state = 3; m_k = 0; m_fp = 0; m_ts = m_tcnt;
                        emit_sample(sd);
                    end else begin
                        if (frc) m_fp = 1;
                        if (din_valid) begin m_pv = 1; m_pm = meet; end
                    end
                end
                3: if (din_valid) emit_sample(sd);
                default: ;
            endcase
        end
        if (bus_wr && mapped) begin
            case (off)
                1: begin r_arm = bus_wdata[0]; r_edge = bus_wdata[1]; r_pol = bus_wdata[2]; end
                2: r_thr  = int'($signed(bus_wdata[15:0]));
                3: r_dec  = int'(bus_wdata[15:0]);
                4: r_len  = int'(bus_wdata[15:0]);
                6: r_hold = int'(bus_wdata[15:0]);
                default: ;
            endcase
        end
        m_tcnt++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("we", 32'(we), 32'(e_we));
        if (e_we) check("dout", 32'(dout), 32'(e_dout));
        check("rvalid", 32'(bus_rvalid), 32'(e_rv));
        check("rdata", bus_rdata, e_rd);
        if (we) got.push_back(int'(dout));
        last_rd   = bus_rdata;
        bus_wr    = 0;
        bus_rd    = 0;
        din_valid = 0;
    endtask

    task automatic bwrite(input int off, input logic [31:0] data);
        bus_addr = AW'(BASE + off); bus_wdata = data; bus_wr = 1;
        cycle();
    endtask

    task automatic bread(input int off);
        bus_addr = AW'(BASE + off); bus_rd = 1;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        resetn = 0;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_we", 32'(we), 0);
        check("reset_dout", 32'(dout), 0);
        check("reset_rdata", bus_rdata, 0);
        check("reset_rvalid", 32'(bus_rvalid), 0);
        resetn = 1;
    endtask

    initial begin
        int cnt1, first_we, idx, wait_n;
        bit [31:0] ts_a;
        resetn = 0; din = 0; din_valid = 0; bus_addr = 0; bus_wdata = 0; bus_wr = 0; bus_rd = 0;
        do_reset();

        for (int o = 0; o < 8; o++) bread(o);
        bread(9);
        bread(0);
        check("id_literal", last_rd, 32'h7C16);
        bread(9);
        check("unmapped_rdata", last_rd, 0);
        bus_addr = 8'd3; bus_rd = 1; cycle();
        bwrite(0, 32'h1234); bwrite(5, 32'hF); bwrite(7, 32'hFFFF);
        bread(0); bread(5); bread(7);

        // level trigger on a ramp
        bwrite(2, 100); bwrite(3, 0); bwrite(4, 4); bwrite(6, 0);
        got.delete();
        bwrite(1, 1);
        idle(2);
        for (int v = 95; v <= 110; v++) begin din = 16'(v); din_valid = 1; cycle(); end
        check("ramp_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("ramp_sample", 32'(got[i]), 32'(100 + i));
        bread(5);
        check("ramp_status", last_rd, 32'hC);

        // falling edge trigger ignores the first sample in WAIT
        bwrite(2, 0); bwrite(4, 1);
        got.delete();
        bwrite(1, 7);
        idle(2);
        din = -16'sd5; din_valid = 1; cycle();
        din = 16'sd10; din_valid = 1; cycle();
        din = -16'sd3; din_valid = 1; cycle();
        idle(2);
        check("edge_count", 32'(got.size()), 1);
        if (got.size() > 0) check("edge_sample", 32'(got[0]), 32'hFFFF_FFFD);

        // decimation with valid on alternate cycles
        bwrite(2, 32'hFFFF_8000); bwrite(3, 2); bwrite(4, 3);
        got.delete();
        bwrite(1, 1);
        idle(2);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) begin din = 16'(idx); din_valid = 1; idx++; end
            cycle();
        end
        check("decim_count", 32'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("decim_sample", 32'(got[i]), 32'(3 * i));

        // holdoff of five cycles then immediate level trigger
        bwrite(6, 5); bwrite(3, 0); bwrite(4, 2);
        got.delete();
        din = 16'($urandom_range(0, 1000)); din_valid = 1;
        bwrite(1, 1);
        cnt1 = 0; first_we = -1;
        for (int i = 0; i < 12; i++) begin
            din = 16'($urandom_range(0, 1000)); din_valid = 1;
            bread(5);
            if (last_rd[2:0] == 3'd1) cnt1++;
            if (we && first_we < 0) first_we = i;
        end
        check("holdoff_cycles", 32'(cnt1), 5);
        check("holdoff_first_we", 32'(first_we), 5);

        // force in WAIT captures the next valid sample
        bwrite(2, 32'h7FFF); bwrite(4, 1); bwrite(6, 0);
        got.delete();
        bwrite(1, 1);
        idle(2);
        din = 16'sd7; din_valid = 1; cycle();
        bwrite(1, 32'h9);
        idle(2);
        din = 16'sd42; din_valid = 1; cycle();
        idle(1);
        check("force_count", 32'(got.size()), 1);
        if (got.size() > 0) check("force_sample", 32'(got[0]), 42);

        // re-arm and disarm in the middle of an unlimited capture
        bwrite(2, 32'hFFFF_8000); bwrite(4, 0); bwrite(3, 1);
        bwrite(1, 1);
        for (int i = 0; i < 8; i++) begin din = 16'(i); din_valid = 1; cycle(); end
        bread(7);
        ts_a = last_rd;
        din = 16'sd3; din_valid = 1; bwrite(1, 1);
        check("rearm_we_stop", 32'(we), 0);
        bread(5);
        check("rearm_state", last_rd, 1);
        for (int i = 0; i < 6; i++) begin din = 16'(i); din_valid = 1; cycle(); end
        bread(7);
`ifdef DC_TRIGGER_TSTAMP_EN
        check("tstamp_updated", 32'(last_rd != ts_a), 1);
`else
        check("tstamp_absent", last_rd ^ ts_a, 0);
`endif
        din = 16'sd3; din_valid = 1; bwrite(1, 0);
        check("disarm_we_stop", 32'(we), 0);
        bread(5);
        check("disarm_state", last_rd, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r, o;
            logic [31:0] d;
            din       = 16'(int'($urandom_range(0, 40)) - 20);
            din_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                d = 32'($urandom_range(0, 15));
                if (r < 2) d[0] = 1'b1;
                bus_addr = AW'(BASE + 1); bus_wdata = d; bus_wr = 1;
            end else if (r < 9) begin
                o = int'($urandom_range(0, 7));
                case (o)
                    2: d = 32'(int'($urandom_range(0, 20)) - 10);
                    3: d = 32'($urandom_range(0, 3));
                    4: d = 32'($urandom_range(0, 6));
                    6: d = 32'($urandom_range(0, 4));
                    default: d = $urandom;
                endcase
                if (o == 1) o = 6;
                bus_addr = AW'(BASE + o); bus_wdata = d; bus_wr = 1;
            end else if (r < 40) begin
                bus_addr = (r < 12) ? AW'($urandom_range(0, 255)) : AW'(BASE + int'($urandom_range(0, 9)));
                bus_rd = 1;
            end
            cycle();
        end

        // asynchronous reset during capture
        bwrite(2, 32'hFFFF_8000); bwrite(3, 0); bwrite(4, 0); bwrite(6, 0);
        bwrite(1, 1);
        wait_n = 0;
        do begin
            din = 16'(wait_n); din_valid = 1; cycle(); wait_n++;
        end while (!we && wait_n < 20);
        check("capture_reached", 32'(we), 1);
        #2;
        resetn = 0;
        #1;
        check("async_reset_we", 32'(we), 0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1;
        for (int o = 0; o < 8; o++) bread(o);
        bread(5);
        check("post_reset_status", last_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
